// File: rtl/nnacc_mm_sched_if.sv
// Job descriptor bus between the matrix-multiply scheduler and the dot-product datapath.
interface nnacc_mm_sched_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_lhs_addr;
    logic [AW-1:0] job_rhs_addr;
    logic [AW-1:0] job_dst_addr;
    logic [DW-1:0] job_len;
    logic          job_last;
    logic          job_done;

    // scheduler side
    modport master (
        output job_valid, job_lhs_addr, job_rhs_addr, job_dst_addr, job_len, job_last,
        input  job_ready, job_done
    );

    // datapath side
    modport slave (
        input  job_valid, job_lhs_addr, job_rhs_addr, job_dst_addr, job_len, job_last,
        output job_ready, job_done
    );
endinterface

// File: rtl/nnacc_mm_sched.sv
// Matrix-multiply job scheduler: walks every (lhs row, rhs row) output element
// and issues one dot-product job per element, one job outstanding at a time.
module nnacc_mm_sched #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          nice_clk,
    input  logic          nice_rst,
    input  logic          start,
    input  logic [DW-1:0] lhs_rows,
    input  logic [DW-1:0] rhs_rows,
    input  logic [DW-1:0] rhs_cols,
    input  logic [AW-1:0] lhs_addr,
    input  logic [AW-1:0] rhs_addr,
    input  logic [AW-1:0] dst_addr,
    nnacc_mm_sched_if.master job,
    output logic [1:0]    state,
    output logic          fin,
    output logic          busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    // latched run configuration (lhs/dst bases live only in the running pointers)
    typedef struct packed {
        logic [DW-1:0] lhs_rows;
        logic [DW-1:0] rhs_rows;
        logic [DW-1:0] rhs_cols;
        logic [AW-1:0] rhs_addr;
    } cfg_t;

    cfg_t          cfg;
    logic [DW-1:0] r;
    logic [DW-1:0] c;
    logic [AW-1:0] lp;
    logic [AW-1:0] rp;
    logic [AW-1:0] dp;
    logic          last_row;
    logic          last_col;
    logic          zero_dim;
    logic [AW-1:0] stride;

    assign last_row = (r == cfg.lhs_rows - DW'(1));
    assign last_col = (c == cfg.rhs_rows - DW'(1));
    assign zero_dim = (lhs_rows == '0) || (rhs_rows == '0) || (rhs_cols == '0);
    // row stride in bytes equals the dot-product length (int8, row-major)
    assign stride   = AW'(cfg.rhs_cols);

    // outputs are pure decodes of registered state, so ready/done never reach them combinationally
    assign job.job_valid    = (state == ISSUE);
    assign job.job_lhs_addr = lp;
    assign job.job_rhs_addr = rp;
    assign job.job_dst_addr = dp;
    assign job.job_len      = cfg.rhs_cols;
    assign job.job_last     = (state == ISSUE) && last_row && last_col;
    assign fin              = (state == FIN);
    assign busy             = (state != IDLE);

    // run sequencer: latch on start, issue/wait per element, c inner and r outer
    always_ff @(posedge nice_clk or posedge nice_rst) begin
        if (nice_rst) begin
            state <= IDLE;
            cfg   <= '0;
            r     <= '0;
            c     <= '0;
            lp    <= '0;
            rp    <= '0;
            dp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg.lhs_rows <= lhs_rows;
                        cfg.rhs_rows <= rhs_rows;
                        cfg.rhs_cols <= rhs_cols;
                        cfg.rhs_addr <= rhs_addr;
                        r     <= '0;
                        c     <= '0;
                        lp    <= lhs_addr;
                        rp    <= rhs_addr;
                        dp    <= dst_addr;
                        state <= zero_dim ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (job.job_ready) state <= WAIT;
                end
                WAIT: begin
                    if (job.job_done) begin
                        if (last_row && last_col) begin
                            state <= FIN;
                        end else begin
                            dp <= dp + AW'(1);
                            if (!last_col) begin
                                c  <= c + DW'(1);
                                rp <= rp + stride;
                            end else begin
                                c  <= '0;
                                rp <= cfg.rhs_addr;
                                r  <= r + DW'(1);
                                lp <= lp + stride;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
